// File: rtl/bounded_response_monitor.sv
// Bounded trigger/response monitor: per-channel IDLE/WAIT checker with
// sticky flags, strobes, last-kind codes and a saturating violation count.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           enable; low freezes channel state and history
//   clear        sync clear of viol, viol_kind, viol_count
//   a[N], b[N]   per-channel trigger / response
//   pending[N]   channel waiting for a response
//   viol[N]      sticky violation flag
//   viol_pulse   one-cycle violation strobe
//   viol_kind    2 bits per channel: 01 timeout, 10 overlap, 11 spurious
//   viol_count   saturating total of violations
module bounded_response_monitor #(
  parameter int N         = 4,
  parameter int MAX_DELAY = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     viol,
  output logic [N-1:0]     viol_pulse,
  output logic [2*N-1:0]   viol_kind,
  output logic [CNT_W-1:0] viol_count
);

  localparam int TW = $clog2(MAX_DELAY + 1);
  localparam int PW = $clog2(N + 1);
  localparam int SW = CNT_W + PW + 1;

  localparam logic [TW-1:0]    TMAX    = TW'(MAX_DELAY);
  localparam logic [TW-1:0]    TONE    = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_TMO  = 2'b01;
  localparam logic [1:0] K_OVL  = 2'b10;
  localparam logic [1:0] K_SPUR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e [N-1:0]          state_q, state_d;
  logic [N-1:0][TW-1:0]    timer_q, timer_d;
  logic [N-1:0]            viol_q, viol_d;
  logic [N-1:0]            pulse_q, pulse_d;
  logic [N-1:0][1:0]       kind_q, kind_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [N-1:0][1:0]       kind_new;
  logic [N-1:0]            flag;
  logic [SW-1:0]           nflag;
  logic [SW-1:0]           sum;
  logic [CNT_W-1:0]        count_base;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    kind_new = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        unique case (state_q[i])
          IDLE: begin
            unique case (1'b1)
              a[i] && !b[i]: begin
                state_d[i] = WAIT;
                timer_d[i] = TONE;
              end
              !a[i] && b[i]: kind_new[i] = K_SPUR;
              default: ;
            endcase
          end
          WAIT: begin
            unique case (1'b1)
              b[i]: begin
                // a discharge on the same edge as a new trigger re-arms
                state_d[i] = a[i] ? WAIT : IDLE;
                timer_d[i] = a[i] ? TONE : '0;
              end
              !b[i] && (timer_q[i] == TMAX): begin
                kind_new[i] = K_TMO;
                state_d[i]  = a[i] ? WAIT : IDLE;
                timer_d[i]  = a[i] ? TONE : '0;
              end
              default: begin
                // overlapping trigger keeps the original deadline
                timer_d[i] = timer_q[i] + TONE;
                if (a[i]) kind_new[i] = K_OVL;
              end
            endcase
          end
          default: begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    flag  = '0;
    nflag = '0;
    for (int i = 0; i < N; i++) begin
      flag[i] = (kind_new[i] != K_NONE);
      nflag   = nflag + SW'(flag[i]);
    end
  end

  always_comb begin
    viol_d  = clear ? '0 : viol_q;
    kind_d  = clear ? '0 : kind_q;
    pulse_d = flag;
    for (int i = 0; i < N; i++) begin
      if (flag[i]) begin
        viol_d[i] = 1'b1;
        kind_d[i] = kind_new[i];
      end
    end
    count_base = clear ? '0 : count_q;
    sum        = SW'(count_base) + nflag;
    count_d    = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {N{IDLE}};
      timer_q <= '0;
      viol_q  <= '0;
      pulse_q <= '0;
      kind_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      viol_q  <= viol_d;
      pulse_q <= pulse_d;
      kind_q  <= kind_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pending[i] = (state_q[i] == WAIT);
    end
  end

  assign viol       = viol_q;
  assign viol_pulse = pulse_q;
  assign viol_kind  = kind_q;
  assign viol_count = count_q;

endmodule

// File: tb/tb_bounded_response_monitor.sv
// Directed bench for bounded_response_monitor (N=2, MAX_DELAY=4, CNT_W=2).
// Table of per-edge vectors plus reset-mid-obligation sequence.
module tb_bounded_response_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] pending;
  logic [1:0] viol;
  logic [1:0] viol_pulse;
  logic [3:0] viol_kind;
  logic [1:0] viol_count;

  int checks   = 0;
  int failures = 0;

  bounded_response_monitor #(
    .N(2),
    .MAX_DELAY(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clear(clear),
    .a(a),
    .b(b),
    .pending(pending),
    .viol(viol),
    .viol_pulse(viol_pulse),
    .viol_kind(viol_kind),
    .viol_count(viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] pend;
    logic [1:0] viol;
    logic [1:0] pulse;
    logic [3:0] kind;
    logic [1:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic       e,
    input logic       c,
    input logic [1:0] ta,
    input logic [1:0] tb,
    input logic [1:0] p,
    input logic [1:0] v,
    input logic [1:0] pu,
    input logic [3:0] k,
    input logic [1:0] n
  );
    vec_t r;
    r.en    = e;
    r.clr   = c;
    r.a     = ta;
    r.b     = tb;
    r.pend  = p;
    r.viol  = v;
    r.pulse = pu;
    r.kind  = k;
    r.cnt   = n;
    return r;
  endfunction

  task automatic chk(
    input string      nm,
    input int         idx,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("pending", idx, 8'(pending), 8'(v.pend));
    chk("viol", idx, 8'(viol), 8'(v.viol));
    chk("viol_pulse", idx, 8'(viol_pulse), 8'(v.pulse));
    chk("viol_kind", idx, 8'(viol_kind), 8'(v.kind));
    chk("viol_count", idx, 8'(viol_count), 8'(v.cnt));
  endtask

  initial begin
    vec_t z;
    z = mk(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'd0);

    // timeout + spurious on ch0
    tv.push_back(mk(1,0,2'b01,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b01, 2'b00,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b01,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b00,2'b01,2'b01,4'b0001,2'd1));
    tv.push_back(mk(1,0,2'b00,2'b01, 2'b00,2'b01,2'b01,4'b0011,2'd2));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b00,2'b01,2'b00,4'b0011,2'd2));
    // overlap on ch1, zero-delay discharge, saturation
    tv.push_back(mk(1,0,2'b10,2'b00, 2'b10,2'b01,2'b00,4'b0011,2'd2));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b10,2'b01,2'b00,4'b0011,2'd2));
    tv.push_back(mk(1,0,2'b10,2'b00, 2'b10,2'b11,2'b10,4'b1011,2'd3));
    tv.push_back(mk(1,0,2'b00,2'b10, 2'b00,2'b11,2'b00,4'b1011,2'd3));
    tv.push_back(mk(1,0,2'b10,2'b10, 2'b00,2'b11,2'b00,4'b1011,2'd3));
    tv.push_back(mk(1,0,2'b00,2'b01, 2'b00,2'b11,2'b01,4'b1011,2'd3));
    tv.push_back(mk(1,1,2'b00,2'b00, 2'b00,2'b00,2'b00,4'b0000,2'd0));
    // enable freeze
    tv.push_back(mk(1,0,2'b01,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(0,0,2'b00,2'b01, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b01,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b00,2'b01,2'b01,4'b0001,2'd1));
    tv.push_back(mk(0,0,2'b00,2'b01, 2'b00,2'b01,2'b00,4'b0001,2'd1));
    // dual timeout twice, reopen, saturate, clear vs new violation
    tv.push_back(mk(1,1,2'b11,2'b00, 2'b11,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b11,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b11,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b11,2'b00,2'b00,4'b0000,2'd0));
    tv.push_back(mk(1,0,2'b11,2'b00, 2'b11,2'b11,2'b11,4'b0101,2'd2));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b11,2'b11,2'b00,4'b0101,2'd2));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b11,2'b11,2'b00,4'b0101,2'd2));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b11,2'b11,2'b00,4'b0101,2'd2));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b00,2'b11,2'b11,4'b0101,2'd3));
    tv.push_back(mk(1,1,2'b00,2'b01, 2'b00,2'b01,2'b01,4'b0011,2'd1));
    tv.push_back(mk(1,0,2'b00,2'b00, 2'b00,2'b01,2'b00,4'b0011,2'd1));

    rst_n = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk_all(-1, z);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_pend", i, 8'(pending), 8'h0);
      chk("idle_viol", i, 8'(viol), 8'h0);
      chk("idle_count", i, 8'(viol_count), 8'h0);
    end

    for (int i = 0; i < tv.size(); i++) begin
      en    = tv[i].en;
      clear = tv[i].clr;
      a     = tv[i].a;
      b     = tv[i].b;
      step();
      chk_all(i, tv[i]);
    end

    // abandon an obligation via reset, two edges into WAIT
    en    = 1'b1;
    clear = 1'b0;
    a     = 2'b01;
    b     = 2'b00;
    step();
    a = 2'b00;
    step();
    chk("pre_rst_pend", 0, 8'(pending), 8'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(100, z);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_pend", i, 8'(pending), 8'h0);
      chk("post_rst_viol", i, 8'(viol), 8'h0);
      chk("post_rst_pulse", i, 8'(viol_pulse), 8'h0);
      chk("post_rst_count", i, 8'(viol_count), 8'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
